// File: rtl/ising_seq_engine.sv
// ising_seq_engine: instruction-driven run sequencer for the Ising-machine controller.
// Each run executes instruction words (pop mask, push mask, push_zero, switch, rep)
// against NUM_CH read/write AXIS streams and drives per-channel DAC samples.
// Ports:
//   clk, rst (async active-low)           clock and reset
//   run_trig / abort / halt               run control levels
//   run_done, state_out                   run status (registered)
//   instr_t*                              instruction AXIS sink (ready is combinational)
//   rd_t*                                 read-FIFO heads, pop via rd_tready (combinational)
//   wr_t*                                 write-FIFO pushes (registered, never stalls)
//   dac_data / dac_valid                  DAC samples (registered)
//   mac_val_in / nl_val_in, mac_run/nl_run ADC samples and enables
//   err_flags, instr_count, exec_count    sticky errors and saturating run statistics
module ising_seq_engine #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REP_W  = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        run_trig,
  input  logic                        abort,
  input  logic                        halt,
  output logic                        run_done,
  input  logic [2*NUM_CH+2+REP_W-1:0] instr_tdata,
  input  logic                        instr_tvalid,
  output logic                        instr_tready,
  input  logic [NUM_CH*DATA_W-1:0]    rd_tdata,
  input  logic [NUM_CH-1:0]           rd_tvalid,
  output logic [NUM_CH-1:0]           rd_tready,
  output logic [NUM_CH*DATA_W-1:0]    wr_tdata,
  output logic [NUM_CH-1:0]           wr_tvalid,
  input  logic [NUM_CH-1:0]           wr_tready,
  output logic [NUM_CH*DATA_W-1:0]    dac_data,
  output logic [NUM_CH-1:0]           dac_valid,
  input  logic [DATA_W-1:0]           mac_val_in,
  input  logic [DATA_W-1:0]           nl_val_in,
  output logic                        mac_run,
  output logic                        nl_run,
  output logic [2:0]                  err_flags,
  output logic [CNT_W-1:0]            instr_count,
  output logic [CNT_W-1:0]            exec_count,
  output logic [1:0]                  state_out
);

  localparam int unsigned INSTR_W = 2*NUM_CH+2+REP_W;
  localparam int unsigned BUS_W   = NUM_CH*DATA_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q;
  logic              out_sel_q;
  logic [REP_W-1:0]  rep_cnt_q;

  // Instruction field decode
  logic [NUM_CH-1:0] pop_c;
  logic [NUM_CH-1:0] push_c;
  logic              push_zero_c;
  logic              switch_c;
  logic [REP_W-1:0]  rep_c;

  assign pop_c       = instr_tdata[NUM_CH-1:0];
  assign push_c      = instr_tdata[2*NUM_CH-1:NUM_CH];
  assign push_zero_c = instr_tdata[2*NUM_CH];
  assign switch_c    = instr_tdata[2*NUM_CH+1];
  assign rep_c       = instr_tdata[INSTR_W-1 -: REP_W];
  assign state_out   = 2'(state_q);

  logic              exec_c;
  logic              last_c;
  logic              end_c;
  logic              sel_d;
  logic [DATA_W-1:0] out_val_c;
  logic [BUS_W-1:0]  wr_data_d;
  logic [REP_W-1:0]  rep_cnt_d;
  logic [CNT_W-1:0]  exec_cnt_d;
  logic [CNT_W-1:0]  instr_cnt_d;
  logic [2:0]        err_d;

  // Execute qualification, handshakes and next-value arithmetic
  always_comb begin
    exec_c       = 1'b0;
    last_c       = 1'b0;
    end_c        = 1'b0;
    sel_d        = out_sel_q;
    out_val_c    = mac_val_in;
    wr_data_d    = '0;
    rep_cnt_d    = rep_cnt_q;
    exec_cnt_d   = exec_count;
    instr_cnt_d  = instr_count;
    err_d        = err_flags;
    rd_tready    = '0;
    instr_tready = 1'b0;

    // Abort wins over execution, so no FIFO is popped on an abort cycle
    exec_c = (state_q == S_RUN) && instr_tvalid && !abort;
    last_c = (rep_cnt_q == rep_c);
    end_c  = halt && !instr_tvalid && (rep_cnt_q == '0);

    // Switch takes effect on the first repeat and already steers that cycle's push
    sel_d     = out_sel_q ^ (exec_c && switch_c && (rep_cnt_q == '0));
    out_val_c = sel_d ? nl_val_in : mac_val_in;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_data_d[i*DATA_W +: DATA_W] = push_zero_c ? '0 : out_val_c;
    end

    rep_cnt_d   = last_c ? '0 : rep_cnt_q + REP_W'(1);
    exec_cnt_d  = (exec_count != CNT_MAX) ? exec_count + CNT_W'(1) : exec_count;
    instr_cnt_d = (last_c && (instr_count != CNT_MAX)) ? instr_count + CNT_W'(1) : instr_count;

    err_d[0] = err_flags[0] | (exec_c && ((pop_c & ~rd_tvalid) != '0));
    err_d[1] = err_flags[1] | ((wr_tvalid & ~wr_tready) != '0);
    err_d[2] = err_flags[2];

    if (exec_c) begin
      rd_tready    = pop_c;
      instr_tready = last_c;
    end
  end

  // Run FSM with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      run_done    <= 1'b1;
      out_sel_q   <= 1'b0;
      rep_cnt_q   <= '0;
      dac_data    <= '0;
      dac_valid   <= '0;
      wr_tdata    <= '0;
      wr_tvalid   <= '0;
      mac_run     <= 1'b0;
      nl_run      <= 1'b0;
      err_flags   <= '0;
      instr_count <= '0;
      exec_count  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run_trig) begin
            state_q     <= S_RUN;
            run_done    <= 1'b0;
            mac_run     <= 1'b1;
            nl_run      <= 1'b1;
            err_flags   <= '0;
            instr_count <= '0;
            exec_count  <= '0;
            rep_cnt_q   <= '0;
          end
        end
        S_RUN: begin
          if (abort || end_c) begin
            state_q   <= S_DONE;
            run_done  <= 1'b1;
            mac_run   <= 1'b0;
            nl_run    <= 1'b0;
            wr_tvalid <= '0;
            dac_valid <= '0;
            rep_cnt_q <= '0;
            err_flags <= err_d | {abort, 2'b00};
          end else begin
            err_flags <= err_d;
            if (exec_c) begin
              dac_data    <= rd_tdata;
              dac_valid   <= '1;
              wr_tvalid   <= push_c;
              wr_tdata    <= wr_data_d;
              out_sel_q   <= sel_d;
              rep_cnt_q   <= rep_cnt_d;
              exec_count  <= exec_cnt_d;
              instr_count <= instr_cnt_d;
            end else begin
              wr_tvalid <= '0;
            end
          end
        end
        S_DONE: begin
          if (!run_trig && !halt && !abort) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ising_seq_engine.sv
// Self-checking bench for ising_seq_engine: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a model.
module tb_ising_seq_engine;

  localparam int unsigned NCH = 3;
  localparam int unsigned DW  = 16;
  localparam int unsigned RW  = 4;
  localparam int unsigned CW  = 32;
  localparam int unsigned IW  = 2*NCH+2+RW;
  localparam longint unsigned CMAX = (64'd1 << CW) - 64'd1;

  logic              clk;
  logic              rst;
  logic              run_trig, abort, halt, run_done;
  logic [IW-1:0]     instr_tdata;
  logic              instr_tvalid, instr_tready;
  logic [NCH*DW-1:0] rd_tdata;
  logic [NCH-1:0]    rd_tvalid, rd_tready;
  logic [NCH*DW-1:0] wr_tdata;
  logic [NCH-1:0]    wr_tvalid, wr_tready;
  logic [NCH*DW-1:0] dac_data;
  logic [NCH-1:0]    dac_valid;
  logic [DW-1:0]     mac_val_in, nl_val_in;
  logic              mac_run, nl_run;
  logic [2:0]        err_flags;
  logic [CW-1:0]     instr_count, exec_count;
  logic [1:0]        state_out;

  int total = 0;
  int bad   = 0;

  ising_seq_engine #(.NUM_CH(NCH), .DATA_W(DW), .REP_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .run_trig(run_trig), .abort(abort), .halt(halt),
    .run_done(run_done), .instr_tdata(instr_tdata), .instr_tvalid(instr_tvalid),
    .instr_tready(instr_tready), .rd_tdata(rd_tdata), .rd_tvalid(rd_tvalid),
    .rd_tready(rd_tready), .wr_tdata(wr_tdata), .wr_tvalid(wr_tvalid),
    .wr_tready(wr_tready), .dac_data(dac_data), .dac_valid(dac_valid),
    .mac_val_in(mac_val_in), .nl_val_in(nl_val_in), .mac_run(mac_run),
    .nl_run(nl_run), .err_flags(err_flags), .instr_count(instr_count),
    .exec_count(exec_count), .state_out(state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // Reference model: run phase (0 idle, 1 run, 2 done), executions done on the
  // current head instruction, and the values every registered output must hold.
  int              m_state, m_rep;
  bit              m_run_done, m_mac_run, m_nl_run, m_sel, m_hs;
  bit [2:0]        m_err;
  longint unsigned m_instr, m_exec;
  bit [NCH-1:0]    m_wrv, m_dacv;
  bit [DW-1:0]     m_dac [NCH];
  bit [DW-1:0]     m_wr  [NCH];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_rep = 0; m_run_done = 1'b1; m_mac_run = 1'b0; m_nl_run = 1'b0;
    m_sel = 1'b0; m_hs = 1'b0; m_err = '0; m_instr = 0; m_exec = 0;
    m_wrv = '0; m_dacv = '0;
    for (int c = 0; c < NCH; c++) begin m_dac[c] = '0; m_wr[c] = '0; end
  endtask

  task automatic model_step();
    bit [NCH-1:0] pop, push;
    bit           pz, sw;
    int           rep;
    bit [DW-1:0]  val;
    pop  = instr_tdata[NCH-1:0];
    push = instr_tdata[2*NCH-1:NCH];
    pz   = instr_tdata[2*NCH];
    sw   = instr_tdata[2*NCH+1];
    rep  = int'(instr_tdata[IW-1 -: RW]);
    m_hs = 1'b0;
    case (m_state)
      0: if (run_trig) begin
        m_state = 1; m_run_done = 1'b0; m_mac_run = 1'b1; m_nl_run = 1'b1;
        m_err = '0; m_instr = 0; m_exec = 0; m_rep = 0;
      end
      1: begin
        if ((m_wrv & ~wr_tready) != '0) m_err[1] = 1'b1;
        if (abort || (halt && !instr_tvalid && m_rep == 0)) begin
          if (abort) m_err[2] = 1'b1;
          m_state = 2; m_run_done = 1'b1; m_mac_run = 1'b0; m_nl_run = 1'b0;
          m_wrv = '0; m_dacv = '0; m_rep = 0;
        end else if (instr_tvalid) begin
          if (sw && m_rep == 0) m_sel = !m_sel;
          val = pz ? '0 : (m_sel ? nl_val_in : mac_val_in);
          for (int c = 0; c < NCH; c++) begin
            m_dac[c] = rd_tdata[c*DW +: DW];
            m_wr[c]  = val;
          end
          m_dacv = '1;
          m_wrv  = push;
          if ((pop & ~rd_tvalid) != '0) m_err[0] = 1'b1;
          if (m_exec < CMAX) m_exec++;
          if (m_rep == rep) begin
            m_rep = 0; m_hs = 1'b1;
            if (m_instr < CMAX) m_instr++;
          end else begin
            m_rep = (m_rep + 1) % 16;
          end
        end else begin
          m_wrv = '0;
        end
      end
      default: if (!run_trig && !halt && !abort) m_state = 0;
    endcase
  endtask

  task automatic check_regs();
    chk("state_out", 64'(state_out), 64'(m_state));
    chk("run_done", 64'(run_done), 64'(m_run_done));
    chk("mac_run", 64'(mac_run), 64'(m_mac_run));
    chk("nl_run", 64'(nl_run), 64'(m_nl_run));
    chk("err_flags", 64'(err_flags), 64'(m_err));
    chk("instr_count", 64'(instr_count), 64'(m_instr));
    chk("exec_count", 64'(exec_count), 64'(m_exec));
    chk("wr_tvalid", 64'(wr_tvalid), 64'(m_wrv));
    chk("dac_valid", 64'(dac_valid), 64'(m_dacv));
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("dac_data%0d", c), 64'(dac_data[c*DW +: DW]), 64'(m_dac[c]));
      chk($sformatf("wr_tdata%0d", c), 64'(wr_tdata[c*DW +: DW]), 64'(m_wr[c]));
    end
  endtask

  task automatic check_comb();
    bit ex;
    ex = (m_state == 1) && instr_tvalid && !abort;
    chk("rd_tready", 64'(rd_tready), 64'(ex ? instr_tdata[NCH-1:0] : '0));
    chk("instr_tready", 64'(instr_tready),
        64'(ex && (m_rep == int'(instr_tdata[IW-1 -: RW]))));
  endtask

  // One clock: check readies on current inputs, advance model, check registers.
  task automatic tick();
    #1;
    check_comb();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_regs();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check_regs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic start_run();
    run_trig = 1'b1; tick(); run_trig = 1'b0;
  endtask

  task automatic end_run();
    instr_tvalid = 1'b0; halt = 1'b1; tick();
    halt = 1'b0; tick();
  endtask

  function automatic logic [IW-1:0] rand_instr();
    logic [IW-1:0] r;
    r = IW'($urandom);
    r[IW-1 -: RW] = ($urandom_range(0, 7) == 0) ? RW'($urandom_range(0, 15))
                                                : RW'($urandom_range(0, 2));
    return r;
  endfunction

  initial begin
    rst = 1'b1; run_trig = 1'b0; abort = 1'b0; halt = 1'b0;
    instr_tdata = '0; instr_tvalid = 1'b0;
    rd_tdata = '0; rd_tvalid = '1; wr_tready = '1;
    mac_val_in = '0; nl_val_in = '0;
    model_reset();
    @(negedge clk);
    do_reset();
    chk("reset_run_done", 64'(run_done), 64'd1);
    chk("reset_err", 64'(err_flags), 64'd0);

    // Pop all, then push out_val to all
    start_run();
    halt = 1'b1; instr_tvalid = 1'b1; instr_tdata = 12'h007;
    rd_tdata = {16'h0c03, 16'h0b02, 16'h0a01};
    #1 chk("t1_rd_tready", 64'(rd_tready), 64'h7);
    tick();
    chk("t1_dac0", 64'(dac_data[15:0]), 64'h0a01);
    instr_tdata = 12'h038; mac_val_in = 16'h1234;
    tick();
    chk("t1_wr_tvalid", 64'(wr_tvalid), 64'h7);
    chk("t1_wr2", 64'(wr_tdata[47:32]), 64'h1234);
    instr_tvalid = 1'b0;
    tick();
    chk("t1_done", 64'(run_done), 64'd1);
    chk("t1_instr_count", 64'(instr_count), 64'd2);
    chk("t1_err", 64'(err_flags), 64'd0);
    halt = 1'b0; tick();

    // rep=3 pop ch0: four pops, ready only on the last
    start_run();
    instr_tvalid = 1'b1; instr_tdata = 12'h301;
    for (int k = 0; k < 4; k++) begin
      rd_tdata[15:0] = 16'(16'h0100 + k);
      #1 chk("t2_instr_tready", 64'(instr_tready), 64'(k == 3));
      tick();
      chk("t2_dac0", 64'(dac_data[15:0]), 64'(16'h0100 + k));
    end
    instr_tvalid = 1'b0; halt = 1'b1; tick();
    chk("t2_exec_count", 64'(exec_count), 64'd4);
    chk("t2_instr_count", 64'(instr_count), 64'd1);
    halt = 1'b0; tick();

    // switch rep=2 pushing ch1: all pushes carry nl
    start_run();
    mac_val_in = 16'h0100; nl_val_in = 16'h0200;
    instr_tvalid = 1'b1; instr_tdata = 12'h290;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3_wr_tvalid", 64'(wr_tvalid), 64'h2);
      chk("t3_wr1", 64'(wr_tdata[31:16]), 64'h0200);
    end
    end_run();

    // underflow and overflow, run continues
    start_run();
    instr_tvalid = 1'b1; instr_tdata = 12'h004; rd_tvalid = 3'b011;
    tick();
    chk("t4_err_underflow", 64'(err_flags), 64'h1);
    rd_tvalid = '1; instr_tdata = 12'h010; wr_tready = 3'b101;
    tick();
    instr_tvalid = 1'b0;
    tick();
    chk("t4_err_overflow", 64'(err_flags), 64'h3);
    chk("t4_still_run", 64'(state_out), 64'd1);
    wr_tready = '1;
    end_run();

    // abort mid-repeat
    start_run();
    instr_tvalid = 1'b1; instr_tdata = 12'hF01;
    for (int k = 0; k < 5; k++) tick();
    abort = 1'b1;
    #1 chk("t5_abort_rd_tready", 64'(rd_tready), 64'd0);
    tick();
    chk("t5_state", 64'(state_out), 64'd2);
    chk("t5_err", 64'(err_flags), 64'h4);
    chk("t5_exec_count", 64'(exec_count), 64'd5);
    chk("t5_instr_count", 64'(instr_count), 64'd0);
    chk("t5_done_rd_tready", 64'(rd_tready), 64'd0);
    chk("t5_done_instr_tready", 64'(instr_tready), 64'd0);
    abort = 1'b0; instr_tvalid = 1'b0; tick();

    // reset mid-run, then a clean restart
    start_run();
    instr_tvalid = 1'b1; instr_tdata = 12'h03F;
    for (int k = 0; k < 3; k++) tick();
    do_reset();
    chk("t6_run_done", 64'(run_done), 64'd1);
    chk("t6_exec_count", 64'(exec_count), 64'd0);
    chk("t6_wr_tvalid", 64'(wr_tvalid), 64'd0);
    instr_tvalid = 1'b0;
    start_run();
    chk("t6_restart_state", 64'(state_out), 64'd1);
    chk("t6_restart_exec", 64'(exec_count), 64'd0);
    end_run();

    // randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 799) == 0) do_reset();
      run_trig = ($urandom_range(0, 7) == 0);
      halt     = ($urandom_range(0, 9) == 0);
      abort    = ($urandom_range(0, 79) == 0);
      if (m_hs || m_rep == 0) instr_tdata = rand_instr();
      instr_tvalid = ($urandom_range(0, 4) != 0);
      for (int c = 0; c < NCH; c++) begin
        rd_tvalid[c] = ($urandom_range(0, 15) != 0);
        wr_tready[c] = ($urandom_range(0, 15) != 0);
        rd_tdata[c*DW +: DW] = DW'($urandom);
      end
      mac_val_in = DW'($urandom);
      nl_val_in  = DW'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ising_seq_engine.md
Name: ising_seq_engine

Overview:
- Parametrised, instruction-driven run sequencer: the next generation of the Ising-machine experiment controller.
- Generalises the fixed alpha/beta/gamma scheme to NUM_CH variable streams, each with an external AXIS read FIFO and AXIS write FIFO.
- Adds per-instruction repeat counts, overflow/underflow error flags, an abort input and run statistics counters.
- Sits between the CPU-fed instruction/variable FIFOs and the DAC/ADC drivers.

Parameters:
NUM_CH, 3, number of variable channels (each has read stream, write stream, DAC output)
DATA_W, 16, sample width
REP_W, 4, repeat field width; instruction executes rep+1 cycles
CNT_W, 32, width of statistics counters
INSTR_W, 2*NUM_CH+2+REP_W, derived localparam, not overridable

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
run_trig  in  1  level; start run from IDLE
abort  in  1  level; force end of run
halt  in  1  end run when instruction FIFO empties
run_done  out  1  high when not running
instr_tdata  in  INSTR_W  instruction word
instr_tvalid  in  1  AXIS valid
instr_tready  out  1  AXIS ready (combinational)
rd_tdata  in  NUM_CH*DATA_W  read-FIFO heads, ch i at [i*DATA_W +: DATA_W]
rd_tvalid  in  NUM_CH  per-channel valid
rd_tready  out  NUM_CH  per-channel pop (combinational)
wr_tdata  out  NUM_CH*DATA_W  write-FIFO data
wr_tvalid  out  NUM_CH  per-channel push (registered)
wr_tready  in  NUM_CH  write-FIFO not full
dac_data  out  NUM_CH*DATA_W  DAC samples (registered)
dac_valid  out  NUM_CH  DAC valid
mac_val_in  in  DATA_W  MAC ADC sample
nl_val_in  in  DATA_W  NL ADC sample
mac_run  out  1  MAC ADC enable
nl_run  out  1  NL ADC enable
err_flags  out  3  sticky: [0] pop underflow, [1] push overflow, [2] abort
instr_count  out  CNT_W  instructions retired this run
exec_count  out  CNT_W  execution cycles this run
state_out  out  2  0 IDLE, 1 RUN, 2 DONE

Behaviour:
- Reset (async, rst=0):
  - run_done=1; out_sel=0; rep_cnt=0.
  - All other outputs 0: dac_*, wr_*, mac_run, nl_run, err_flags, counters.
- Instruction fields:
  - [NUM_CH-1:0] pop mask.
  - [2*NUM_CH-1:NUM_CH] push mask.
  - [2*NUM_CH] push_zero: 1 pushes 0, else pushes out_val.
  - [2*NUM_CH+1] switch.
  - Top REP_W bits: rep.
  - out_val = out_sel ? nl_val_in : mac_val_in.
- IDLE:
  - run_trig=1 -> RUN.
  - Same edge: run_done<=0, mac_run<=1, nl_run<=1, err_flags<=0, counters<=0, rep_cnt<=0.
- RUN, exec = instr_tvalid:
  - rd_tready[i] = exec & pop[i].
  - instr_tready = exec & (rep_cnt==rep).
  - On exec, per cycle:
    - dac_data<=rd_tdata; dac_valid<=all ones.
    - wr_tvalid[i]<=push[i]; wr_tdata[i]<=push_zero?0:out_val.
    - exec_count++.
    - If rep_cnt==rep: rep_cnt<=0 and instr_count++; else rep_cnt++.
  - switch toggles out_sel only on the cycle where rep_cnt==0.
  - No exec: wr_tvalid<=0, dac_data held, dac_valid held, rep_cnt held.
- Errors:
  - err_flags[0] set if exec & pop[i] & !rd_tvalid[i], any i.
  - err_flags[1] set if wr_tvalid[i] & !wr_tready[i]. The push is dropped; no stall.
  - The engine never stalls on data FIFOs.
- Counters saturate at all-ones.
- End of run, RUN -> DONE:
  - Normal end: halt & !instr_tvalid & rep_cnt==0.
  - Forced end: abort=1 at any point in RUN. Sets err_flags[2] and abandons a partial repeat.
  - On entry to DONE: run_done<=1, mac_run<=0, nl_run<=0, wr_tvalid<=0, dac_valid<=0, rep_cnt<=0.
  - Combinational readies are 0 in DONE.
- DONE -> IDLE when run_trig, halt and abort are all 0. Counters and err_flags hold until the next run start.
- Precedence inside RUN: abort > end-of-run > exec.
- Reset mid-run returns immediately to reset values. FIFO contents are external and untouched.

Test Plan:
- Run with NUM_CH=3, instrs 0x007 (pop all), 0x038 (push out to all), halt=1 → rd_tready=111 one cycle, then wr_tvalid=111 with mac_val_in; instr_count=2, run_done=1, err_flags=0.
- Instr with rep=3, pop ch0, ch0 FIFO holds 4 values → 4 consecutive pops, dac_data ch0 tracks each value; instr_tready high only on 4th cycle; exec_count=4, instr_count=1.
- Switch with rep=2, mac=0x0100, nl=0x0200, push out to ch1 → out_sel toggles once; all three pushes carry 0x0200.
- Pop ch2 with rd_tvalid[2]=0 → err_flags=001. Push ch1 with wr_tready[1]=0 → err_flags[1]=1. Run continues in both cases.
- abort mid-repeat (rep=15, cycle 5) → DONE next edge; err_flags[2]=1, exec_count=5, instr_count=0, readies 0.
- rst low during RUN → immediate run_done=1 and all other outputs 0. A following run_trig starts cleanly with counters 0.
